// File: rtl/i2c_master.sv
// i2c_master: single-master I2C initiator (START, addr+R/W, multi-byte write/read, ACK/NACK, STOP).
// Define I2C_MASTER_STRETCH_EN to let a slave stretch scl during the high phase of each slot.
module i2c_master #(
   parameter int CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        sda,
   inout  wire        scl,
   input  logic       enable,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       data_req,
   output logic       busy,
   output logic       ack_error
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          rw_q, rw_d;
   logic          ack_q, ack_d;
   logic          sda_oe_q, sda_oe_d;
   logic          scl_oe_q, scl_oe_d;
   logic          busy_q, busy_d;
   logic          ack_error_q, ack_error_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          data_valid_q, data_valid_d;
   logic          data_req_q, data_req_d;
   logic          stall;
   logic          tick;

`ifdef I2C_MASTER_STRETCH_EN
   // only a slave can hold scl low while we have released it in q2
   assign stall = qtr_q == 2'd2 && !scl_oe_q && scl == 1'b0;
`else
   assign stall = 1'b0;
`endif
   assign tick = div_q == DIV_MAX && !stall;

   always_comb begin
      state_d = state_q;
      div_d = '0;
      qtr_d = qtr_q;
      bit_d = bit_q;
      shift_d = shift_q;
      wdata_d = wdata_q;
      rw_d = rw_q;
      ack_d = ack_q;
      ack_error_d = ack_error_q;
      data_out_d = data_out_q;
      data_valid_d = 1'b0;
      data_req_d = 1'b0;
      if (state_q == IDLE) begin
         qtr_d = 2'd0;
         if (enable) begin
            state_d = START;
            shift_d = {addr, rw};
            wdata_d = data_in;
            rw_d = rw;
            ack_error_d = 1'b0;
         end
      end else begin
         div_d = (tick || stall) ? '0 : div_q + 1'b1;
         if (tick)
            qtr_d = qtr_q + 2'd1;
         if (tick && qtr_q == 2'd2) begin
            if (state_q == READ)
               shift_d = {shift_q[6:0], sda == 1'b1};
            if ((state_q == ADDR_ACK || state_q == WRITE_ACK) && sda == 1'b1)
               ack_error_d = 1'b1;
         end
         if (tick && qtr_q == 2'd3) begin
            case (state_q)
               START: state_d = ADDR;
               ADDR, WRITE: begin
                  shift_d = {shift_q[6:0], 1'b0};
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7)
                     state_d = state_q == ADDR ? ADDR_ACK : WRITE_ACK;
               end
               ADDR_ACK: begin
                  state_d = ack_error_q ? STOP : rw_q ? READ : WRITE;
                  shift_d = wdata_q;
               end
               WRITE_ACK: begin
                  state_d = (ack_error_q || !enable) ? STOP : WRITE;
                  shift_d = (ack_error_q || !enable) ? shift_q : data_in;
                  data_req_d = !ack_error_q && enable;
               end
               READ: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = READ_ACK;
                     data_out_d = shift_q;
                     data_valid_d = 1'b1;
                     ack_d = enable;
                  end
               end
               READ_ACK: state_d = ack_q ? READ : STOP;
               default: state_d = IDLE;
            endcase
         end
      end
      busy_d = state_d != IDLE;
      scl_oe_d = state_d != IDLE && !qtr_d[1];
      sda_oe_d = 1'b0;
      case (state_d)
         START: begin
            scl_oe_d = qtr_d[1];
            sda_oe_d = qtr_d != 2'd0;
         end
         STOP: begin
            scl_oe_d = qtr_d == 2'd0;
            sda_oe_d = !qtr_d[1];
         end
         ADDR, WRITE: sda_oe_d = !shift_d[7];
         READ_ACK: sda_oe_d = ack_d;
         default: sda_oe_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q <= '0;
         qtr_q <= 2'd0;
         bit_q <= 3'd0;
         shift_q <= 8'd0;
         wdata_q <= 8'd0;
         rw_q <= 1'b0;
         ack_q <= 1'b0;
         sda_oe_q <= 1'b0;
         scl_oe_q <= 1'b0;
         busy_q <= 1'b0;
         ack_error_q <= 1'b0;
         data_out_q <= 8'd0;
         data_valid_q <= 1'b0;
         data_req_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q <= div_d;
         qtr_q <= qtr_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         wdata_q <= wdata_d;
         rw_q <= rw_d;
         ack_q <= ack_d;
         sda_oe_q <= sda_oe_d;
         scl_oe_q <= scl_oe_d;
         busy_q <= busy_d;
         ack_error_q <= ack_error_d;
         data_out_q <= data_out_d;
         data_valid_q <= data_valid_d;
         data_req_q <= data_req_d;
      end
   end

   assign sda = sda_oe_q ? 1'b0 : 1'bz;
   assign scl = scl_oe_q ? 1'b0 : 1'bz;
   assign data_out = data_out_q;
   assign data_valid = data_valid_q;
   assign data_req = data_req_q;
   assign busy = busy_q;
   assign ack_error = ack_error_q;
endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master I2C initiator; it is the counterpart of the team's i2c_slave1 responder on the same open-drain sda/scl pair.
- Generates START, the 7-bit address plus R/W bit, multi-byte write and read data phases, ACK/NACK handling and STOP from a single system clock.
- Drives sda/scl open-drain (only 0 or z). The board provides pull-ups.
- Supports clock stretching by a slave that holds scl low, as i2c_slave1 does on interrupt.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL period. One SCL bit = 4*CLK_DIV clk cycles. Legal range is ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sda  inout  1  I2C data; driven 0 or z only
- scl  inout  1  I2C clock; driven 0 or z only
- enable  input  1  in IDLE, high starts a transaction; at each byte boundary, high continues and low ends
- addr  input  7  target slave address, latched at start
- rw  input  1  0 = write, 1 = read; latched at start
- data_in  input  8  write byte; latched at start and at each data_req
- data_out  output  8  last byte read
- data_valid  output  1  one-cycle pulse when data_out is updated
- data_req  output  1  one-cycle pulse when data_in is latched for the next write byte
- busy  output  1  high from the cycle after start until STOP completes
- ack_error  output  1  set on a NACK received for address or write data; cleared at the next start

Behaviour:
- Reset values: busy=0, ack_error=0, data_out=0, data_valid=0, data_req=0, sda=z, scl=z, state=IDLE, divider=0.
- Divider: counts 0..CLK_DIV-1. A tick occurs at CLK_DIV-1. The divider is held at 0 in IDLE.
  - Each bit slot has quarters q0..q3, advanced by ticks.
  - q0 and q1: scl driven low. sda is updated at q0 entry.
  - q2 and q3: scl released.
  - sda is sampled on the tick that ends q2.
- IDLE:
  - enable=1 latches addr, rw and data_in, clears ack_error, and enters START. busy=1 on the next cycle.
  - enable while busy is ignored as a new request.
- START: q0: sda z, scl z. q1: sda 0 with scl high, which is the start condition. q2–q3: scl 0. Then ADDR.
- ADDR: 8 slots, MSB first, shifting {addr, rw}. sda is released (z) for 1 bits and driven 0 for 0 bits.
- ADDR_ACK: sda released.
  - Sampled 1: ack_error=1, go to STOP.
  - Sampled 0: go to WRITE when rw=0, READ when rw=1.
- WRITE: 8 slots of the latched byte, MSB first. Then WRITE_ACK with sda released.
  - NACK: ack_error=1, go to STOP.
  - ACK with enable=1: latch data_in, pulse data_req, return to WRITE.
  - ACK with enable=0: go to STOP.
- READ: sda released for 8 slots; sampled bits shift in MSB first. At the end of the 8th slot, data_out is updated and data_valid pulses for one cycle. Then READ_ACK.
  - READ_ACK drives sda 0 (ACK) if enable=1, otherwise releases it (NACK).
  - Next state is READ if enable=1, otherwise STOP.
  - enable is sampled at q0 of the ACK slot.
- STOP: q0: scl 0, sda 0. q1: scl z, sda 0. q2: sda z with scl high, which is the stop condition. q3: idle. Then IDLE, with busy=0 on that cycle.
- Byte count is unbounded; the protocol has no wrap-around.
- rst mid-transaction: sda and scl are released on the next cycle and no STOP is generated. All outputs return to their reset values.
- The address byte is always sent in full, even with no slave present.

Optional Feature:
- Macro I2C_MASTER_STRETCH_EN.
- Defined: in q2 of every slot, the divider stalls while the scl input reads 0. q2 timing restarts once scl reads 1, so a slave can stretch indefinitely.
- Undefined: the scl input is ignored and timing is free-running from the divider.

Test Plan (CLK_DIV=4, so 16 clk cycles per bit):
- Write, addr=0x50, rw=0, data_in=0xA5, enable dropped after start, slave ACKs both bytes -> sda shows START, 1010000 0, ACK, 10100101, ACK, STOP. busy is high throughout, then 0. ack_error=0. data_req never pulses.
- Write to an absent addr 0x11 (sda floats high at the ACK slot) -> ack_error=1. STOP follows immediately after the 9th slot. No data slots occur.
- Read, addr=0x2A, rw=1, slave returns 0x3C then 0xC3, enable held through the first byte only -> data_out=0x3C with a data_valid pulse and master ACK (sda=0); then data_out=0xC3 with a data_valid pulse and master NACK; then STOP.
- Two-byte write 0x12 then 0x34, enable held through the first ACK -> data_req pulses once at the first ACK. Second byte on the wire is 0x34.
- With I2C_MASTER_STRETCH_EN, slave holds scl low for 40 cycles during data bit 3 -> the bit slot extends by ≥40 cycles and all byte values are still correct. Without the macro, the slot length is exactly 16 cycles.
- rst asserted during the 5th bit of a write data byte -> sda=z, scl=z and busy=0 on the next cycle. A new write of 0x7E then completes correctly. An enable pulse while busy does not restart the transaction.
